// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared FSM encoding and baud default for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;
  localparam int CLKS_PER_BIT_DEF = 104;
  localparam logic [2:0] LAST_BIT = 3'd7;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;
endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// baud_gen: bit-period counter with synchronous clear and terminal-count tick.
module baud_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == LAST;
  assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one byte per frame from a registered-output FIFO and sends it as 8N1, LSB first.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_read_o,
  output logic       tx_o,
  output logic       busy_o
);
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       tick;
  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_d != state_q),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE:  if (enable_i && !fifo_empty_i) state_d = FETCH;
      FETCH: state_d = LATCH;
      LATCH: begin
        shift_d = fifo_data_i;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == LAST_BIT) state_d = STOP;
      end
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // tx is computed from the next state so the register lines up with state_q
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end
  assign fifo_read_o = state_q == FETCH;
  assign tx_o        = tx_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random and directed frames checked against an 8N1 waveform model built from the byte value.
module tb_fifo_uart_tx;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_data_i = 8'h00;
  logic       fifo_read_o, tx_o, busy_o;
  int         n_checks = 0;
  int         n_fail = 0;
  int         reads = 0;
  int         since_pop = 0;
  bit         toggle = 1'b0;
  logic [7:0] q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_read_o (fifo_read_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // source FIFO model; optionally scrambles empty/data while a frame is in flight
  always @(negedge clk) begin
    since_pop++;
    if (fifo_read_o) begin
      reads++;
      since_pop = 0;
      fifo_data_i = (q.size() > 0) ? q.pop_front() : 8'hEE;
    end else if (toggle && busy_o && since_pop >= 2) begin
      fifo_data_i = 8'($urandom);
    end
    fifo_empty_i = (toggle && busy_o) ? ~fifo_empty_i : (q.size() == 0);
  end

  task automatic check_frame(input logic [7:0] b, input bit chained, input int drop_at, input string nm);
    int   gap;
    bit   found;
    logic exp;
    gap = chained ? 1 : 0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        found = 1'b1;
        break;
      end
      gap++;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s start: no start bit within 200 cycles, tx=%b required 0", nm, tx_o);
      return;
    end
    if (chained) begin
      n_checks++;
      if (gap !== 3) begin
        n_fail++;
        $display("FAIL %s gap: %0d idle-high cycles, required 3", nm, gap);
      end
    end
    for (int i = 0; i < 10 * N; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) enable_i = 1'b0;
      exp = (i < N) ? 1'b0 : (i >= 9 * N) ? 1'b1 : b[(i / N) - 1];
      n_checks++;
      if (tx_o !== exp || busy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL %s cycle %0d: tx=%b busy=%b, required tx=%b busy=1", nm, i, tx_o, busy_o, exp);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: busy=%b tx=%b after 40 cycles, required busy=0 tx=1", nm, busy_o, tx_o);
    end
  endtask

  task automatic test_reset();
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: tx=%b busy=%b read=%b, required 1 0 0", tx_o, busy_o, fifo_read_o);
    end
    enable_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int r0;
    r0 = reads;
    q.push_back(8'hA5);
    enable_i = 1'b1;
    check_frame(8'hA5, 1'b0, -1, "single_a5");
    enable_i = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (reads !== r0 + 1) begin
      n_fail++;
      $display("FAIL single_a5 reads: %0d pops, required 1", reads - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = reads;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    enable_i = 1'b1;
    check_frame(8'h00, 1'b0, -1, "b2b_00");
    check_frame(8'hFF, 1'b1, -1, "b2b_ff");
    repeat (10) @(negedge clk);
    enable_i = 1'b0;
    n_checks++;
    if (reads !== r0 + 2) begin
      n_fail++;
      $display("FAIL b2b reads: %0d pops, required 2", reads - r0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[4];
    int         r0;
    r0 = reads;
    foreach (b[i]) begin
      b[i] = 8'($urandom);
      q.push_back(b[i]);
    end
    enable_i = 1'b1;
    foreach (b[i]) check_frame(b[i], i > 0, -1, $sformatf("rand%0d_%02h", i, b[i]));
    repeat (10) @(negedge clk);
    enable_i = 1'b0;
    n_checks++;
    if (reads !== r0 + 4) begin
      n_fail++;
      $display("FAIL rand reads: %0d pops, required 4", reads - r0);
    end
  endtask

  task automatic test_disabled();
    int r0;
    int bad;
    r0 = reads;
    bad = 0;
    q.push_back(8'h42);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_read_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0 || reads !== r0) begin
      n_fail++;
      $display("FAIL disabled: %0d bad cycles %0d pops, required 0 and 0", bad, reads - r0);
    end
    q.delete();
  endtask

  task automatic test_enable_drop();
    int r0;
    r0 = reads;
    q.push_back(8'h3C);
    q.push_back(8'h99);
    enable_i = 1'b1;
    check_frame(8'h3C, 1'b0, 5 * N + 1, "drop_3c");
    repeat (20) @(negedge clk);
    n_checks++;
    if (reads !== r0 + 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_3c after: %0d pops busy=%b, required 1 pop busy=0", reads - r0, busy_o);
    end
    q.delete();
  endtask

  task automatic test_reset_mid();
    int r0;
    bit found;
    r0 = reads;
    found = 1'b0;
    q.push_back(8'h5A);
    q.push_back(8'h11);
    enable_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_mid start: no start bit, tx=%b required 0", tx_o);
    end
    repeat (6 * N + 1) @(negedge clk);
    enable_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid async: tx=%b busy=%b read=%b, required 1 0 0", tx_o, busy_o, fifo_read_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (reads !== r0 + 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid idle: %0d pops busy=%b, required 1 pop busy=0", reads - r0, busy_o);
    end
    enable_i = 1'b1;
    check_frame(8'h11, 1'b0, -1, "rst_mid_11");
    enable_i = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (reads !== r0 + 2) begin
      n_fail++;
      $display("FAIL rst_mid reads: %0d pops, required 2", reads - r0);
    end
  endtask

  task automatic test_empty_toggle();
    int r0;
    r0 = reads;
    toggle = 1'b1;
    q.push_back(8'h81);
    enable_i = 1'b1;
    check_frame(8'h81, 1'b0, -1, "toggle_81");
    enable_i = 1'b0;
    repeat (10) @(negedge clk);
    toggle = 1'b0;
    n_checks++;
    if (reads !== r0 + 1) begin
      n_fail++;
      $display("FAIL toggle_81 reads: %0d pops, required 1", reads - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_disabled();
    test_enable_drop();
    test_reset_mid();
    test_empty_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
